// File: rtl/bpred_gshare_btb_pkg.sv
//------------------------------------------------------------------------------
// Module      : bpred_gshare_btb_pkg
// Description : Shared types and constants for the gshare/BTB branch predictor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bpred_gshare_btb_pkg;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Weakly-not-taken reset value of a CTR_W-bit counter; 0 for a 1-bit counter.
    function automatic int bp_wnt(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpred_gshare_btb_if.sv
//------------------------------------------------------------------------------
// Module      : bpred_gshare_btb_if
// Description : Fetch lookup, execute update and status signals of the predictor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bpred_gshare_btb_if #(
    parameter int IDX_W = 6
);
    logic             i_flush;
    logic [31:0]      i_pred_pc;
    logic             o_pred_taken;
    logic             o_pred_hit;
    logic [31:0]      o_pred_target;
    logic [IDX_W-1:0] o_pred_idx;
    logic             i_upd_valid;
    logic [31:0]      i_upd_pc;
    logic [IDX_W-1:0] i_upd_idx;
    logic             i_upd_taken;
    logic [31:0]      i_upd_target;
    logic             i_upd_mispredict;
    logic             o_ready;
    logic [31:0]      o_mispred_cnt;

    modport master (
        output i_flush, i_pred_pc, i_upd_valid, i_upd_pc, i_upd_idx,
               i_upd_taken, i_upd_target, i_upd_mispredict,
        input  o_pred_taken, o_pred_hit, o_pred_target, o_pred_idx,
               o_ready, o_mispred_cnt
    );

    modport slave (
        input  i_flush, i_pred_pc, i_upd_valid, i_upd_pc, i_upd_idx,
               i_upd_taken, i_upd_target, i_upd_mispredict,
        output o_pred_taken, o_pred_hit, o_pred_target, o_pred_idx,
               o_ready, o_mispred_cnt
    );
endinterface

`default_nettype wire

// File: rtl/bp_sat_counter.sv
//------------------------------------------------------------------------------
// Module      : bp_sat_counter
// Description : Next-value function of a CTR_W-bit up/down saturating counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_sat_counter #(
    parameter int CTR_W = 2
) (
    input  wire logic [CTR_W-1:0] i_value,
    input  wire logic             i_up,
    output logic      [CTR_W-1:0] o_value
);

    always_comb begin
        o_value = i_value;
        if (i_up) begin
            if (i_value != '1) begin
                o_value = i_value + CTR_W'(1);
            end
        end else if (i_value != '0) begin
            o_value = i_value - CTR_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bpred_gshare_btb.sv
//------------------------------------------------------------------------------
// Module      : bpred_gshare_btb
// Description : Bimodal/gshare counter table plus tagged BTB with INIT sweep.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bpred_gshare_btb
    import bpred_gshare_btb_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8,
    parameter int MODE    = 1,
    parameter int GHR_W   = 6
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bpred_gshare_btb_if.slave    bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] c_wnt = CTR_W'(bp_wnt(CTR_W));

    bp_state_e          r_state;
    bp_state_e          w_state_next;
    logic [IDX_W-1:0]   r_init_idx;
    logic [GHR_W-1:0]   r_ghr;
    logic [31:0]        r_mispred_cnt;

    // Flop arrays kept separate so the INIT sweep can later map onto RAM.
    logic [CTR_W-1:0]   r_ctr        [ENTRIES];
    logic               r_btb_valid  [ENTRIES];
    logic [TAG_W-1:0]   r_btb_tag    [ENTRIES];
    logic [31:0]        r_btb_target [ENTRIES];

    logic [IDX_W-1:0]   w_pred_bidx;
    logic [TAG_W-1:0]   w_pred_tag;
    logic [IDX_W-1:0]   w_pred_cidx;
    logic [IDX_W-1:0]   w_upd_bidx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic [CTR_W-1:0]   w_ctr_next;
    logic               w_pred_hit;
    logic               w_upd_en;
    logic               w_unused_pc;

    assign w_pred_bidx = bus.i_pred_pc[IDX_W+1:2];
    assign w_pred_tag  = bus.i_pred_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_upd_bidx  = bus.i_upd_pc[IDX_W+1:2];
    assign w_upd_tag   = bus.i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_unused_pc = ^{bus.i_pred_pc, bus.i_upd_pc};

    always_comb begin
        w_pred_cidx = w_pred_bidx;
        if (MODE == BP_GSHARE) begin
            w_pred_cidx = w_pred_bidx ^ IDX_W'(r_ghr);
        end else if (MODE == BP_BIMODAL) begin
            w_pred_cidx = w_pred_bidx;
        end
    end

    // Flush shares the update's cycle and wins over it.
    assign w_upd_en = (r_state == BP_RUN) && bus.i_upd_valid && !bus.i_flush;

    bp_sat_counter #(
        .CTR_W   (CTR_W)
    ) u_sat_counter (
        .i_value (r_ctr[bus.i_upd_idx]),
        .i_up    (bus.i_upd_taken),
        .o_value (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.i_flush) begin
            r_state    <= BP_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == BP_INIT) begin
                r_init_idx <= r_init_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BP_INIT: begin
                if (r_init_idx == IDX_W'(ENTRIES - 1)) begin
                    w_state_next = BP_RUN;
                end
            end
            BP_RUN:  w_state_next = BP_RUN;
            default: w_state_next = BP_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.i_flush) begin
            if (r_state == BP_INIT) begin
                r_ctr[r_init_idx]       <= c_wnt;
                r_btb_valid[r_init_idx] <= 1'b0;
            end else if (bus.i_upd_valid) begin
                r_ctr[bus.i_upd_idx] <= w_ctr_next;
                if (bus.i_upd_taken) begin
                    r_btb_valid[w_upd_bidx]  <= 1'b1;
                    r_btb_tag[w_upd_bidx]    <= w_upd_tag;
                    r_btb_target[w_upd_bidx] <= bus.i_upd_target;
                end
            end
        end
    end

    // The mispredict count survives flush; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr         <= '0;
            r_mispred_cnt <= '0;
        end else if (bus.i_flush) begin
            r_ghr <= '0;
        end else if (w_upd_en) begin
            r_ghr <= GHR_W'({r_ghr, bus.i_upd_taken});
            if (bus.i_upd_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign w_pred_hit = r_btb_valid[w_pred_bidx] && (r_btb_tag[w_pred_bidx] == w_pred_tag);

    always_comb begin
        bus.o_ready       = 1'b0;
        bus.o_pred_hit    = 1'b0;
        bus.o_pred_taken  = 1'b0;
        bus.o_pred_target = '0;
        bus.o_pred_idx    = '0;
        if (r_state == BP_RUN) begin
            bus.o_ready       = 1'b1;
            bus.o_pred_hit    = w_pred_hit;
            bus.o_pred_taken  = w_pred_hit && r_ctr[w_pred_cidx][CTR_W-1];
            bus.o_pred_target = r_btb_target[w_pred_bidx];
            bus.o_pred_idx    = w_pred_cidx;
        end
    end

    assign bus.o_mispred_cnt = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bpred_gshare_btb.sv
//------------------------------------------------------------------------------
// Module      : tb_bpred_gshare_btb
// Description : Bimodal and gshare instances checked against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bpred_gshare_btb;

    localparam int ENTRIES = 64;
    localparam int CTR_MAX = 3;
    localparam int CTR_WNT = 1;
    localparam int TAKEN_TH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_misp = 1'b0;
    logic [5:0]  upd_idx [2];

    logic        obs_ready [2];
    logic        obs_hit   [2];
    logic        obs_taken [2];
    logic [31:0] obs_tgt   [2];
    logic [5:0]  obs_idx   [2];
    logic [31:0] obs_cnt   [2];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state, one slot per instance (0 = bimodal, 1 = gshare).
    int          m_ctr   [2][ENTRIES];
    bit          m_valid [2][ENTRIES];
    int          m_tag   [2][ENTRIES];
    logic [31:0] m_tgt   [2][ENTRIES];
    int          m_ghr   [2];
    longint      m_misp  [2];
    int          m_init_left = ENTRIES;

    always #5 clk = ~clk;

    bpred_gshare_btb_if #(.IDX_W(6)) bus0 ();
    bpred_gshare_btb_if #(.IDX_W(6)) bus1 ();

    assign bus0.i_flush = flush;          assign bus1.i_flush = flush;
    assign bus0.i_pred_pc = pred_pc;      assign bus1.i_pred_pc = pred_pc;
    assign bus0.i_upd_valid = upd_valid;  assign bus1.i_upd_valid = upd_valid;
    assign bus0.i_upd_pc = upd_pc;        assign bus1.i_upd_pc = upd_pc;
    assign bus0.i_upd_idx = upd_idx[0];   assign bus1.i_upd_idx = upd_idx[1];
    assign bus0.i_upd_taken = upd_taken;  assign bus1.i_upd_taken = upd_taken;
    assign bus0.i_upd_target = upd_target; assign bus1.i_upd_target = upd_target;
    assign bus0.i_upd_mispredict = upd_misp; assign bus1.i_upd_mispredict = upd_misp;

    assign obs_ready[0] = bus0.o_ready;       assign obs_ready[1] = bus1.o_ready;
    assign obs_hit[0]   = bus0.o_pred_hit;    assign obs_hit[1]   = bus1.o_pred_hit;
    assign obs_taken[0] = bus0.o_pred_taken;  assign obs_taken[1] = bus1.o_pred_taken;
    assign obs_tgt[0]   = bus0.o_pred_target; assign obs_tgt[1]   = bus1.o_pred_target;
    assign obs_idx[0]   = bus0.o_pred_idx;    assign obs_idx[1]   = bus1.o_pred_idx;
    assign obs_cnt[0]   = bus0.o_mispred_cnt; assign obs_cnt[1]   = bus1.o_mispred_cnt;

    bpred_gshare_btb #(
        .ENTRIES(ENTRIES), .CTR_W(2), .TAG_W(8), .MODE(0), .GHR_W(6)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    bpred_gshare_btb #(
        .ENTRIES(ENTRIES), .CTR_W(2), .TAG_W(8), .MODE(1), .GHR_W(6)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int f_bidx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int f_tag(input logic [31:0] pc);
        return int'((pc / (4 * ENTRIES)) % 256);
    endfunction

    function automatic int f_cidx(input int m, input logic [31:0] pc);
        return (m == 1) ? (f_bidx(pc) ^ m_ghr[1]) : f_bidx(pc);
    endfunction

    function automatic logic [31:0] rand_pc();
        return ($urandom & 32'hFFFF_0003) | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
    endfunction

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic mp);
        upd_valid  = v;
        upd_pc     = pc;
        upd_taken  = t;
        upd_target = tgt;
        upd_misp   = mp;
        for (int m = 0; m < 2; m++) upd_idx[m] = 6'(f_cidx(m, pc));
    endtask

    task automatic compare_inst(input int m);
        bit rdy;
        bit hit;
        bit tk;
        int b;
        int c;
        rdy = (m_init_left == 0);
        b   = f_bidx(pred_pc);
        c   = f_cidx(m, pred_pc);
        hit = rdy && m_valid[m][b] && (m_tag[m][b] == f_tag(pred_pc));
        tk  = hit && (m_ctr[m][c] >= TAKEN_TH);
        check($sformatf("m%0d_ready", m), 32'(obs_ready[m]), 32'(rdy));
        check($sformatf("m%0d_hit", m), 32'(obs_hit[m]), 32'(hit));
        check($sformatf("m%0d_taken", m), 32'(obs_taken[m]), 32'(tk));
        check($sformatf("m%0d_idx", m), 32'(obs_idx[m]), rdy ? 32'(c) : 32'd0);
        if (hit) check($sformatf("m%0d_target", m), obs_tgt[m], m_tgt[m][b]);
        if (!rdy) check($sformatf("m%0d_target_init", m), obs_tgt[m], 32'd0);
        check($sformatf("m%0d_mispcnt", m), obs_cnt[m], 32'(m_misp[m]));
    endtask

    task automatic model_edge();
        int b;
        int i;
        if (rst || flush) begin
            m_init_left = ENTRIES;
            for (int m = 0; m < 2; m++) begin
                m_ghr[m] = 0;
                if (rst) m_misp[m] = 0;
                for (int k = 0; k < ENTRIES; k++) begin
                    m_ctr[m][k]   = CTR_WNT;
                    m_valid[m][k] = 1'b0;
                end
            end
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else if (upd_valid) begin
            b = f_bidx(upd_pc);
            for (int m = 0; m < 2; m++) begin
                i = int'(upd_idx[m]);
                if (upd_taken) begin
                    m_ctr[m][i]   = (m_ctr[m][i] < CTR_MAX) ? m_ctr[m][i] + 1 : CTR_MAX;
                    m_valid[m][b] = 1'b1;
                    m_tag[m][b]   = f_tag(upd_pc);
                    m_tgt[m][b]   = upd_target;
                end else begin
                    m_ctr[m][i] = (m_ctr[m][i] > 0) ? m_ctr[m][i] - 1 : 0;
                end
                m_ghr[m] = (m_ghr[m] * 2 + int'(upd_taken)) % ENTRIES;
                if (upd_misp && m_misp[m] < 64'hFFFF_FFFF) m_misp[m]++;
            end
        end
    endtask

    // Check outputs just after the inputs settle, then advance the model with the edge.
    task automatic tick();
        #1;
        for (int m = 0; m < 2; m++) compare_inst(m);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!obs_ready[0] && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd64);
    endtask

    initial begin
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        wait_ready("init_len");

        // Bimodal training at 0x100 with target 0x40.
        pred_pc = 32'h100;
        repeat (4) begin set_upd(1'b1, 32'h100, 1'b1, 32'h40, 1'b0); tick(); end
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        check("train_hit", 32'(obs_hit[0]), 32'd1);
        check("train_taken", 32'(obs_taken[0]), 32'd1);
        check("train_target", obs_tgt[0], 32'h40);
        set_upd(1'b1, 32'h100, 1'b1, 32'h40, 1'b0); tick();
        set_upd(1'b1, 32'h100, 1'b0, '0, 1'b0);
        #1 check("sat_hold_taken", 32'(obs_taken[0]), 32'd1);
        tick();
        #1 check("coll_old", 32'(obs_taken[0]), 32'd1);
        tick();
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        check("coll_new", 32'(obs_taken[0]), 32'd0);
        check("nt_hit", 32'(obs_hit[0]), 32'd1);
        tick();

        // Alias at the same bidx with a different tag.
        pred_pc = 32'h200;
        #1;
        check("alias_hit", 32'(obs_hit[0]), 32'd0);
        check("alias_taken", 32'(obs_taken[0]), 32'd0);
        set_upd(1'b1, 32'h200, 1'b1, 32'h80, 1'b0); tick();
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        pred_pc = 32'h100;
        #1 check("evicted_hit", 32'(obs_hit[0]), 32'd0);
        pred_pc = 32'h200;
        #1 check("alias_new_target", obs_tgt[0], 32'h80);
        tick();

        // Gshare history T,N,T from a clean reset.
        rst = 1'b1; tick(); rst = 1'b0;
        wait_ready("reinit_len");
        set_upd(1'b1, 32'h300, 1'b1, 32'h10, 1'b0); tick();
        set_upd(1'b1, 32'h304, 1'b0, '0, 1'b0); tick();
        set_upd(1'b1, 32'h308, 1'b1, 32'h20, 1'b0); tick();
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        pred_pc = 32'h100;
        #1;
        check("gshare_idx", 32'(obs_idx[1]), 32'h05);
        check("bimodal_idx", 32'(obs_idx[0]), 32'h00);
        tick();

        // Mispredict counter, flush interplay and rst clear.
        repeat (3) begin set_upd(1'b1, 32'h400, 1'b0, '0, 1'b1); tick(); end
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        #1 check("misp_three", obs_cnt[0], 32'd3);
        flush = 1'b1;
        set_upd(1'b1, 32'h100, 1'b1, 32'h44, 1'b1);
        tick();
        flush = 1'b0;
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        wait_ready("flush_init_len");
        check("flush_keeps_cnt", obs_cnt[0], 32'd3);
        pred_pc = 32'h100;
        #1 check("flush_drops_upd", 32'(obs_hit[0]), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        #1 check("rst_clears_cnt", obs_cnt[0], 32'd0);
        wait_ready("rst_init_len");

        force dut0.r_mispred_cnt = 32'hFFFF_FFFF;
        #1 release dut0.r_mispred_cnt;
        m_misp[0] = 64'hFFFF_FFFF;
        set_upd(1'b1, 32'h400, 1'b0, '0, 1'b1); tick();
        set_upd(1'b0, '0, 1'b0, '0, 1'b0);
        #1 check("misp_saturated", obs_cnt[0], 32'hFFFF_FFFF);
        tick();

        // Randomised traffic with occasional flush and reset.
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 499) == 0);
            flush   = ($urandom_range(0, 199) == 0);
            pred_pc = rand_pc();
            set_upd(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 3) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bpred_gshare_btb.md
Name: bpred_gshare_btb

Overview:
- Parametrised dynamic branch predictor for the pipelined core's fetch stage.
- Replaces the fixed 2-bit, single-branch predictor with three structures: a table of saturating counters, a tagged branch target buffer (BTB), and an optional global history register (GHR) for gshare indexing.
- Fetch queries it combinationally with the current PC.
- Execute resolves the branch and writes the outcome back through the update port.

Parameters:
- ENTRIES, 64, number of counter and BTB entries; must be a power of 2 and at least 4; IDX_W = log2(ENTRIES).
- CTR_W, 2, width of each saturating counter; 1 to 4.
- TAG_W, 8, BTB tag width; IDX_W+TAG_W+2 must not exceed 32.
- MODE, 1, counter-table indexing: 0 = bimodal, 1 = gshare.
- GHR_W, 6, global history length; 1 to IDX_W; ignored when MODE=0.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_flush  in  1  one-cycle pulse; invalidates all state and re-runs init.
- i_pred_pc  in  32  fetch PC to predict.
- o_pred_taken  out  1  predict taken.
- o_pred_hit  out  1  BTB hit for i_pred_pc.
- o_pred_target  out  32  predicted target; valid only when o_pred_hit=1.
- o_pred_idx  out  IDX_W  counter index used; carried down the pipe.
- i_upd_valid  in  1  a resolved branch is presented this cycle.
- i_upd_pc  in  32  PC of the resolved branch.
- i_upd_idx  in  IDX_W  o_pred_idx captured at fetch.
- i_upd_taken  in  1  actual outcome.
- i_upd_target  in  32  actual target.
- i_upd_mispredict  in  1  the prediction was wrong.
- o_ready  out  1  high in RUN state.
- o_mispred_cnt  out  32  mispredict counter; saturates.

Behaviour:
- Index and tag
  - bidx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - cidx = bidx when MODE=0; bidx XOR zero-extended GHR when MODE=1.
  - Counter weak-not-taken value WNT = 2^(CTR_W-1)-1. For CTR_W=1, WNT=0.
- FSM states: INIT, RUN.
  - rst=1 or i_flush=1 → INIT with init counter = 0; GHR=0; o_mispred_cnt=0 (clears on rst only, not on flush).
  - INIT: each cycle writes ctr[i]=WNT and btb_valid[i]=0, then increments i. After writing i=ENTRIES-1 → RUN. INIT lasts exactly ENTRIES cycles.
  - rst asserted mid-INIT restarts at i=0. i_flush during INIT restarts at i=0.
  - During INIT: o_ready=0, o_pred_taken=0, o_pred_hit=0, o_pred_target=0; updates are ignored and GHR is frozen.
- Lookup (RUN, combinational, zero latency)
  - o_pred_hit = btb_valid[bidx] AND btb_tag[bidx]==tag.
  - o_pred_taken = o_pred_hit AND ctr[cidx][CTR_W-1].
  - o_pred_target = btb_target[bidx]; o_pred_idx = cidx.
- Update (RUN, i_upd_valid=1, takes effect at the clock edge)
  - ctr[i_upd_idx]: +1 if taken, saturating at 2^CTR_W-1; -1 if not taken, saturating at 0.
  - If taken: btb[upd_bidx] ← {valid=1, tag(i_upd_pc), i_upd_target}, overwriting any alias.
  - If not taken: BTB is unchanged.
  - GHR ← {GHR[GHR_W-2:0], i_upd_taken} (non-speculative).
  - If i_upd_mispredict: o_mispred_cnt increments, holding at 0xFFFFFFFF.
- Simultaneous lookup and update to the same entry: lookup returns the pre-update value; there is no bypass.
- i_flush and i_upd_valid in the same cycle: flush wins and the update is discarded.
- Reset values (visible from the cycle after rst): o_ready=0, o_pred_taken=0, o_pred_hit=0, o_pred_target=0, o_pred_idx=0, o_mispred_cnt=0.
- All state changes occur only on the rising edge of clk.

Decomposition:
- Shared package / GLOBALS additions:
  - FSM state encodings (BP_INIT, BP_RUN).
  - MODE constants (BP_BIMODAL, BP_GSHARE).
  - Helper macro for WNT.
- One natural sub-module: bp_sat_counter (parametrised CTR_W up/down saturating counter, used as the counter-table update function).
- BTB and counter arrays stay in the top module as flop arrays, so that the INIT sweep can later map to RAM.

Test Plan (default parameters unless noted):
- Reset and init: pulse rst for 1 cycle → o_ready=0 for exactly 64 cycles, then 1. Any PC looks up with o_pred_hit=0 and o_pred_taken=0.
- Training:
  - Four taken updates at pc=0x100, target 0x40, MODE=0 → lookup of 0x100 gives hit=1, taken=1, target=0x40.
  - Counter reads 3; a fifth taken update keeps it at 3.
  - Then two not-taken updates → taken=0, hit=1.
- Alias and tag: after training 0x100, look up 0x200 (same bidx, different tag) → hit=0, taken=0. A taken update at 0x200 with target 0x80 → 0x100 now misses.
- Gshare indexing: MODE=1, updates with outcome sequence T,N,T → GHR=0b000101. Lookup of 0x100 gives o_pred_idx = 0x00 XOR 0x05 = 0x05.
- Collisions:
  - Update and lookup of the same index in one cycle → lookup shows the old counter; the next cycle shows the new one.
  - i_flush together with i_upd_valid → update dropped; INIT runs for 64 cycles.
- Mispredict counter: 3 updates with i_upd_mispredict=1 → o_mispred_cnt=3. i_flush leaves it at 3; rst clears it to 0. A preload-forced value of 0xFFFFFFFF stays saturated.
